fpga_clkratio_apb_mst: RTL

FPGA_CLKRATIO_APB_MST -- requirements
Module: fpga_clkratio_apb_mst

---
 rtl/fpga_clkratio_apb_mst_if.sv | 51 +++++
 rtl/fpga_clkratio_apb_mst.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fpga_clkratio_apb_mst_if.sv
// Command/response and APB bus bundle for fpga_clkratio_apb_mst.
//
// Command handshake: a command transfers on a rising per_clk edge when
// cmd_valid and cmd_ready are both high. cmd_valid may rise at any time and
// cmd_write/cmd_addr/cmd_wdata are only looked at in that transfer cycle.
// There is no back-pressure on the response side. rsp_valid is a one-cycle
// pulse, and rsp_rdata/rsp_err/rsp_timeout stay valid until the next pulse.
interface fpga_clkratio_apb_mst_if #(
  parameter int ADDR_W = 12
);
  // command side
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  // response side
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic [7:0]        err_cnt;
  // APB requester controls
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  // APB completer response
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  // The block itself: drives the APB bus and the responses.
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  prdata, pready, pslverr,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout, err_cnt,
    output psel, penable, pwrite, paddr, pwdata
  );

  // The surroundings: the command source plus the APB completer.
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output prdata, pready, pslverr,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout, err_cnt,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/fpga_clkratio_apb_mst.sv
// Single-outstanding APB requester. It takes one command at a time. It runs the
// SETUP and ACCESS phases and optionally aborts a stalled completer after
// TIMEOUT_CYC ACCESS cycles. It reports each completion with a one-cycle pulse
// and keeps a saturating count of erroneous completions.
module fpga_clkratio_apb_mst #(
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                          per_clk,
  input  logic                          clkrst,
  fpga_clkratio_apb_mst_if.master       bus,
  output logic [1:0]                    dbg_state
);

  // The wait counter must be able to hold TIMEOUT_CYC itself.
  localparam int WAIT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  // Count value at the start of the last ACCESS cycle before an abort.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
  localparam bit                TO_EN     = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                accept;
  logic                done;
  logic                abort;

  logic [WAIT_W-1:0]   wait_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [31:0]         pwdata_q;
  logic                rsp_valid_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_err_q;
  logic                rsp_timeout_q;
  logic [7:0]          err_cnt_q;

  // Next-state decode: accept in IDLE, one SETUP cycle, then ACCESS until
  // pready or the wait limit. pready wins over the timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.pready) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (TO_EN && (wait_q == WAIT_LAST)) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; a reset drops any in-flight transfer silently.
  always_ff @(posedge per_clk) begin
    if (clkrst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command capture: the APB address/data/direction are only loaded on accept
  // and otherwise hold, so they stay stable across SETUP, ACCESS and IDLE.
  always_ff @(posedge per_clk) begin
    if (clkrst) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else if (accept) begin
      pwrite_q <= bus.cmd_write;
      paddr_q  <= bus.cmd_addr;
      pwdata_q <= bus.cmd_wdata;
    end
  end

  // Wait counter: cleared while in SETUP so it reads 0 on the first ACCESS
  // cycle, then it counts ACCESS cycles with pready low. It saturates so that
  // a disabled timeout never wraps it.
  always_ff @(posedge per_clk) begin
    if (clkrst) begin
      wait_q <= '0;
    end else if (state_q == ST_SETUP) begin
      wait_q <= '0;
    end else if ((state_q == ST_ACCESS) && !bus.pready && (wait_q != WAIT_MAX)) begin
      wait_q <= wait_q + 1'b1;
    end
  end

  // Response registers: pulse rsp_valid for one cycle, and hold the payload
  // until the next completion.
  always_ff @(posedge per_clk) begin
    if (clkrst) begin
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= done || abort;
      if (done) begin
        rsp_rdata_q   <= pwrite_q ? 32'h0 : bus.prdata;
        rsp_err_q     <= bus.pslverr;
        rsp_timeout_q <= 1'b0;
      end else if (abort) begin
        rsp_rdata_q   <= 32'h0;
        rsp_err_q     <= 1'b1;
        rsp_timeout_q <= 1'b1;
      end
    end
  end

  // Error counter: advances together with an erroneous rsp_valid and sticks at 255.
  always_ff @(posedge per_clk) begin
    if (clkrst) begin
      err_cnt_q <= 8'h00;
    end else if (((done && bus.pslverr) || abort) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  // APB controls and cmd_ready are pure decodes of the registered state.
  assign bus.cmd_ready   = (state_q == ST_IDLE);
  assign bus.psel        = (state_q != ST_IDLE);
  assign bus.penable     = (state_q == ST_ACCESS);
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.err_cnt     = err_cnt_q;
  assign dbg_state       = state_q;

endmodule
